signal_source: RTL and testbench

Synthetic antenna-signal generator for TART test mode and benches. It runs in the external signal-clock domain (`clk_e`) and drives a `WIDTH`-channel bit vector with the same rate and format as the radio front-ends, so the capture, phase-recovery and correlator chain can be exercised end-to-end. All channels carry one shared 16-bit LFSR stream. Each channel has its own programmable integer-sample delay and polarity inversion, giving known inter-channel lags and correlations for verification.

---
 rtl/signal_source_if.sv | 32 +++
 rtl/signal_source.sv | 169 ++++++++++++++++
 tb/tb_signal_source.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/signal_source_if.sv
// Bundle of the signal_source control, configuration and sample-output signals.
// The generator sits on the slave side; whatever drives it (test controller or
// bench) uses the master side.
interface signal_source_if #(
  parameter int WIDTH = 24,
  parameter int CBITS = 5,
  parameter int DBITS = 3,
  parameter int LBITS = 16
) ();

  logic             enable_i;
  logic [LBITS-1:0] length_i;
  logic             set_i;
  logic [CBITS-1:0] chan_i;
  logic [DBITS-1:0] dly_i;
  logic             inv_i;
  logic             busy_o;
  logic             strobe_o;
  logic [WIDTH-1:0] sig_o;
  logic             done_o;

  modport slave (
    input  enable_i, length_i, set_i, chan_i, dly_i, inv_i,
    output busy_o, strobe_o, sig_o, done_o
  );

  modport master (
    output enable_i, length_i, set_i, chan_i, dly_i, inv_i,
    input  busy_o, strobe_o, sig_o, done_o
  );

endinterface

// File: rtl/signal_source.sv
// Synthetic antenna-signal generator. One shared 16-bit LFSR stream feeds a
// D-deep history; each channel taps the history at its own delay and can be
// inverted, giving known inter-channel lags for exercising the capture chain.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for an enable_i rising edge; configuration writable
// S_PRIME | D cycles filling the history so every tap is valid at RUN
// S_RUN   | one sample per cycle on sig_o with strobe_o high
module signal_source #(
  parameter int          WIDTH = 24,
  parameter int          CBITS = 5,
  parameter int          DBITS = 3,
  parameter int          LBITS = 16,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          DELAY = 3
) (
  input logic             clk_e,
  input logic             reset,
  signal_source_if.slave  bus
);

  localparam int D = 1 << DBITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // A zero seed locks the LFSR; too few channel-select bits cannot reach
  // every channel. DELAY only models output skew in simulation and has no
  // hardware meaning, so it is merely range-checked here.
  if (SEED == 16'h0000 || DELAY < 0 || (1 << CBITS) < WIDTH) begin : g_param_check
    $error("signal_source: illegal parameter combination");
  end

  logic [1:0]       state_q;
  logic             en_q;
  logic [LBITS-1:0] len_q;
  logic [LBITS-1:0] cnt_q;
  logic [DBITS-1:0] prime_q;
  logic [15:0]      lfsr_q;
  logic [D-1:0]     hist_q;
  logic [DBITS-1:0] dly_q [WIDTH];
  logic [WIDTH-1:0] inv_q;
  logic             busy_q;
  logic             strobe_q;
  logic             done_q;
  logic [WIDTH-1:0] sig_q;

  logic             start;
  logic             advance;
  logic             fb;
  logic [15:0]      lfsr_nxt;
  logic [D-1:0]     hist_nxt;
  logic [WIDTH-1:0] sig_nxt;
  logic             run_last;

  assign start    = (state_q == S_IDLE) && bus.enable_i && !en_q;
  assign advance  = (state_q == S_PRIME) || (state_q == S_RUN);
  assign fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_nxt = {lfsr_q[14:0], fb};
  assign hist_nxt = {hist_q[D-2:0], lfsr_q[15]};
  assign run_last = !bus.enable_i || ((len_q != '0) && (cnt_q == len_q));

  // Per-channel taps are taken from the history as it will be after this
  // edge, so the registered sample lines up with the strobe it is issued with.
  always_comb begin
    sig_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sig_nxt[i] = hist_nxt[dly_q[i]] ^ inv_q[i];
    end
  end

  // Edge detector on enable_i; a held-high enable never retriggers a run.
  always_ff @(posedge clk_e) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= bus.enable_i;
  end

  // Channel configuration: writable only while idle and only for real channels.
  always_ff @(posedge clk_e) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) dly_q[i] <= '0;
      inv_q <= '0;
    end else if (state_q == S_IDLE && bus.set_i && (int'(bus.chan_i) < WIDTH)) begin
      dly_q[bus.chan_i] <= bus.dly_i;
      inv_q[bus.chan_i] <= bus.inv_i;
    end
  end

  // LFSR and history: reseeded on a start, shifted in PRIME and RUN, held idle.
  always_ff @(posedge clk_e) begin
    if (reset) begin
      lfsr_q <= SEED;
      hist_q <= '0;
    end else if (start) begin
      lfsr_q <= SEED;
      hist_q <= '0;
    end else if (advance) begin
      lfsr_q <= lfsr_nxt;
      hist_q <= hist_nxt;
    end
  end

  // Sequencing FSM with registered busy/strobe/done/sample outputs.
  always_ff @(posedge clk_e) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      prime_q  <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q <= S_PRIME;
            len_q   <= bus.length_i;
            cnt_q   <= '0;
            prime_q <= DBITS'(D - 1);
            busy_q  <= 1'b1;
          end
        end
        S_PRIME: begin
          if (!bus.enable_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (prime_q == '0) begin
            state_q  <= S_RUN;
            cnt_q    <= LBITS'(1);
            strobe_q <= 1'b1;
            sig_q    <= sig_nxt;
          end else begin
            prime_q <= prime_q - DBITS'(1);
          end
        end
        S_RUN: begin
          if (run_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            // In continuous mode the counter wraps and is never compared.
            cnt_q    <= cnt_q + LBITS'(1);
            strobe_q <= 1'b1;
            sig_q    <= sig_nxt;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.strobe_o = strobe_q;
  assign bus.done_o   = done_q;
  assign bus.sig_o    = sig_q;

endmodule

// File: tb/tb_signal_source.sv
// Self-checking bench for signal_source: directed run sequence with random
// channel configuration and burst lengths, checked against a stream model.
module tb_signal_source;

  localparam int          WIDTH = 24;
  localparam int          CBITS = 5;
  localparam int          DBITS = 3;
  localparam int          LBITS = 16;
  localparam int          D     = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          NBITS = 80000;

  logic clk_e = 1'b0;
  logic reset = 1'b1;

  signal_source_if #(.WIDTH(WIDTH), .CBITS(CBITS), .DBITS(DBITS), .LBITS(LBITS)) bus ();

  signal_source #(
    .WIDTH(WIDTH), .CBITS(CBITS), .DBITS(DBITS), .LBITS(LBITS),
    .SEED(SEED), .DELAY(3)
  ) dut (
    .clk_e (clk_e),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_e = ~clk_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: serial LFSR output bit j (bit 15 before the j-th shift)
  // and the per-channel configuration the DUT should currently hold.
  bit s_bits [NBITS];
  int m_dly  [WIDTH];
  bit m_inv  [WIDTH];

  task automatic step();
    @(posedge clk_e);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample k of a run: after D priming shifts the newest history bit is
  // stream bit D-1+k; a channel with delay d sees the bit d shifts older.
  function automatic logic [WIDTH-1:0] exp_sig(input int k);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = s_bits[D - 1 + k - m_dly[i]] ^ m_inv[i];
    return v;
  endfunction

  task automatic cfg(input int ch, input int d, input int inv);
    bus.set_i  = 1'b1;
    bus.chan_i = CBITS'(ch);
    bus.dly_i  = DBITS'(d);
    bus.inv_i  = 1'(inv);
    step();
    bus.set_i  = 1'b0;
    if (ch < WIDTH) begin
      m_dly[ch] = d;
      m_inv[ch] = 1'(inv);
    end
  endtask

  // One run from an enable rising edge. drop_at != 0 lowers enable_i in that
  // cycle (abort if inside PRIME). inject writes channel 1 in mid-RUN, which
  // must be ignored.
  task automatic run(input int len, input int drop_at, input bit inject);
    int end_t;
    bit aborted;
    bit e_busy, e_strobe, e_done;
    logic [WIDTH-1:0] e_sig;
    end_t   = (len != 0) ? D + len : drop_at;
    if (drop_at != 0 && drop_at < end_t) end_t = drop_at;
    aborted = (drop_at != 0) && (drop_at <= D);
    bus.length_i = LBITS'(len);
    bus.enable_i = 1'b1;
    for (int t = 1; t <= end_t + 3; t++) begin
      step();
      if (t == drop_at) bus.enable_i = 1'b0;
      if (inject && t == D + 2) begin
        bus.set_i  = 1'b1;
        bus.chan_i = CBITS'(1);
        bus.dly_i  = DBITS'(m_dly[1] + 1);
        bus.inv_i  = ~m_inv[1];
      end
      if (inject && t == D + 3) bus.set_i = 1'b0;
      e_busy   = (t <= end_t);
      e_strobe = !aborted && (t >= D + 1) && (t <= end_t);
      e_done   = !aborted && (t == end_t + 1);
      e_sig    = e_strobe ? exp_sig(t - D - 1) : '0;
      check("busy",   32'(bus.busy_o),   32'(e_busy));
      check("strobe", 32'(bus.strobe_o), 32'(e_strobe));
      check("done",   32'(bus.done_o),   32'(e_done));
      check("sig",    32'(bus.sig_o),    32'(e_sig));
    end
    bus.enable_i = 1'b0;
    step();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(bus.busy_o),   32'h0);
    check({tag, "_strobe"}, 32'(bus.strobe_o), 32'h0);
    check({tag, "_done"},   32'(bus.done_o),   32'h0);
    check({tag, "_sig"},    32'(bus.sig_o),    32'h0);
  endtask

  initial begin
    logic [15:0] l;
    int rlen;
    l = SEED;
    for (int j = 0; j < NBITS; j++) begin
      s_bits[j] = l[15];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    for (int i = 0; i < WIDTH; i++) begin
      m_dly[i] = 0;
      m_inv[i] = 1'b0;
    end
    bus.enable_i = 1'b0;
    bus.length_i = '0;
    bus.set_i    = 1'b0;
    bus.chan_i   = '0;
    bus.dly_i    = '0;
    bus.inv_i    = 1'b0;

    // cold reset
    reset = 1'b1;
    step();
    check_quiet("rst");
    step();
    reset = 1'b0;
    step();
    check_quiet("idle");

    // burst of 5 with default (zero) configuration
    run(5, 0, 0);

    // lag configuration plus random settings on the remaining channels
    cfg(0, 0, 0);
    cfg(1, 3, 0);
    cfg(2, 7, 1);
    for (int i = 3; i < WIDTH; i++) cfg(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    run(64, 0, 0);

    // writes during RUN and to a nonexistent channel must not take effect
    run(20, 0, 1);
    cfg(30, 5, 1);
    run(20, 0, 0);

    // random burst lengths and a random drop inside RUN
    for (int r = 0; r < 3; r++) begin
      rlen = int'($urandom_range(1, 40));
      run(rlen, 0, 0);
    end
    run(30, D + int'($urandom_range(1, 29)), 0);

    // abort during PRIME
    run(10, 4, 0);

    // reset in mid-RUN clears outputs and configuration
    bus.length_i = LBITS'(30);
    bus.enable_i = 1'b1;
    for (int t = 0; t < 12; t++) step();
    reset = 1'b1;
    bus.enable_i = 1'b0;
    step();
    check_quiet("mrst");
    step();
    reset = 1'b0;
    step();
    check_quiet("mrst_idle");
    for (int i = 0; i < WIDTH; i++) begin
      m_dly[i] = 0;
      m_inv[i] = 1'b0;
    end
    run(12, 0, 0);

    // continuous mode across the sample-counter wrap, then drop enable
    cfg(5, 6, 1);
    run(0, D + 70000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
